instruction_encoder: RTL
========================

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, request present.
REQ-004 SHALL have port in_ready, output, 1, request accepted when in_valid && in_ready at the clock edge.
REQ-005 SHALL have ports opcode (input, 7), rd, rs1 and rs2 (input, 5 each), funct3 (input, 3) and funct7 (input, 7), all instruction fields.
REQ-006 SHALL have port immediate, input, 32, signed byte offset or value.
REQ-007 SHALL have port load_immediate, input, 1, LI pseudo-op request; opcode, rs1, rs2, funct3 and funct7 are ignored when set.
REQ-008 SHALL have port out_valid, output, 1, encoded word present.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts word when out_valid && out_ready.
REQ-010 SHALL have port instruction, output, 32, encoded RV32I word.
REQ-011 SHALL have port error, output, 1, immediate unencodable for the selected format; qualified by out_valid.

Function
REQ-012 SHALL map opcode to format as follows: Load, Immediate_Arithmetic and Jump_And_Link_Register map to I. Store maps to S. Branch maps to B. Add_Upper_Immediate_To_Program_Counter and Load_Upper_Immediate map to U. Jump_And_Link maps to J. All other opcodes map to R.
REQ-013 SHALL pack fields per the RV32I layout; R uses funct7, rs2, rs1, funct3 and rd. I places immediate[11:0] in bits [31:20]. S splits immediate[11:5] and [4:0]. B places imm[12|10:5] in bits [31:25] and imm[4:1|11] in bits [11:7]. U places imm[31:12] in bits [31:12]. J places imm[20|10:1|11|19:12] in bits [31:12].
REQ-014 SHALL set error for the following: I or S with immediate outside -2048..2047. B with immediate outside -4096..4094 or odd. J with immediate outside -1048576..1048574 or odd. U with immediate[11:0] nonzero. R never sets error.
REQ-015 SHALL output instruction = 0 with error = 1 on an error; the error word SHALL still complete a normal out handshake.
REQ-016 SHALL assert in_ready = (state == IDLE) && (!out_valid || out_ready).
REQ-017 SHALL present an accepted request on out_valid in the next cycle, giving 1-cycle latency.
REQ-018 SHALL hold instruction, error and out_valid stable while out_valid && !out_ready.
REQ-019 SHALL have states IDLE and EXPAND.
- IDLE: on an accepted LI whose immediate fits -2048..2047, emit one word, ADDI rd,x0,imm, and stay in IDLE.
- IDLE: on an accepted LI whose immediate does not fit, emit LUI rd,hi with hi = (imm + 0x800) >> 12 (32-bit wrap), latch lo = imm[11:0] and rd, and go to EXPAND.
- EXPAND: when the LUI word is accepted, emit ADDI rd,rd,lo and go to IDLE.
REQ-020 SHALL never set error for LI; every 32-bit value is encodable.
REQ-021 SHALL, when a new request is accepted in the same cycle the current word is consumed, replace the output without a bubble.

Reset
REQ-022 SHALL on reset drive out_valid=0, instruction=0, error=0, state=IDLE, and clear the latched LI rd and lo.
REQ-023 SHALL abandon a pending EXPAND on reset; the ADDI beat is never emitted.
REQ-024 SHALL hold in_ready=0 in the cycle reset is asserted.

Structure
REQ-025 SHALL take opcode_t and the opcode names from the shared opcodes package; an instruction_format_t enum and the immediate range limits SHALL be added there.
REQ-026 SHALL place format decode, packing and range check in a combinational sub-module instruction_packer; the encoder SHALL hold only the handshake, output register and EXPAND FSM.

Verification
REQ-027 SHALL cover: ADDI, with opcode 0x13, rd=1, rs1=2, funct3=0 and imm=-1 -> 0xFFF10093, error=0, one cycle after accept.
REQ-028 SHALL cover: JAL, with opcode 0x6F, rd=0 and imm=-8 -> 0xFF9FF06F; the same with imm=-7 -> instruction=0, error=1.
REQ-029 SHALL cover: LI with rd=5 and imm=0x12345FFF -> 0x123462B7, then 0xFFF28293, with in_ready=0 between the two beats; LI with rd=5 and imm=100 -> a single word 0x06400293.
REQ-030 SHALL cover: out_ready held low 3 cycles with a word pending -> instruction stable and in_ready=0 throughout; accept and new request in the same cycle -> no idle cycle.
REQ-031 SHALL cover: Branch with imm=4096 -> error=1; Load_Upper_Immediate with imm=0x00001001 -> error=1.
REQ-032 SHALL cover: reset asserted the cycle after the LUI beat of an expanding LI -> out_valid=0 next cycle, no ADDI emitted, next request encodes normally.

Source files
------------

// File: rtl/instruction_encoder_pkg.sv
// Shared opcode names plus the format and immediate-range definitions
// used by the RV32I instruction encoder.
package instruction_encoder_pkg;

  typedef enum logic [6:0] {
    Load                                   = 7'h03,
    Immediate_Arithmetic                   = 7'h13,
    Add_Upper_Immediate_To_Program_Counter = 7'h17,
    Store                                  = 7'h23,
    Register_Arithmetic                    = 7'h33,
    Load_Upper_Immediate                   = 7'h37,
    Branch                                 = 7'h63,
    Jump_And_Link_Register                 = 7'h67,
    Jump_And_Link                          = 7'h6F
  } opcode_t;

  typedef enum logic [2:0] {
    FORMAT_R,
    FORMAT_I,
    FORMAT_S,
    FORMAT_B,
    FORMAT_U,
    FORMAT_J
  } instruction_format_t;

  typedef enum logic {
    IDLE,
    EXPAND
  } encoder_state_t;

  localparam logic signed [31:0] IMM12_MIN  = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX  = 32'sd2047;
  localparam logic signed [31:0] BRANCH_MIN = -32'sd4096;
  localparam logic signed [31:0] BRANCH_MAX = 32'sd4094;
  localparam logic signed [31:0] JUMP_MIN   = -32'sd1048576;
  localparam logic signed [31:0] JUMP_MAX   = 32'sd1048574;

  function automatic instruction_format_t format_of(logic [6:0] opcode);
    case (opcode_t'(opcode))
      Load, Immediate_Arithmetic, Jump_And_Link_Register: format_of = FORMAT_I;
      Store:                                              format_of = FORMAT_S;
      Branch:                                             format_of = FORMAT_B;
      Add_Upper_Immediate_To_Program_Counter,
      Load_Upper_Immediate:                               format_of = FORMAT_U;
      Jump_And_Link:                                      format_of = FORMAT_J;
      default:                                            format_of = FORMAT_R;
    endcase
  endfunction

endpackage

// File: rtl/instruction_encoder_packer.sv
// Combinational RV32I packer: decodes the format from the opcode, packs the
// fields and flags immediates the format cannot represent.
module instruction_packer
  import instruction_encoder_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] immediate,
  output logic [31:0] instruction,
  output logic        error
);

  instruction_format_t format;
  logic signed [31:0]  signed_imm;
  logic [31:0]         packed_word;
  logic                range_error;

  always_comb begin
    format      = format_of(opcode);
    signed_imm  = $signed(immediate);
    packed_word = '0;
    range_error = 1'b0;
    case (format)
      FORMAT_I: begin
        packed_word = {immediate[11:0], rs1, funct3, rd, opcode};
        range_error = (signed_imm < IMM12_MIN) || (signed_imm > IMM12_MAX);
      end
      FORMAT_S: begin
        packed_word = {immediate[11:5], rs2, rs1, funct3, immediate[4:0], opcode};
        range_error = (signed_imm < IMM12_MIN) || (signed_imm > IMM12_MAX);
      end
      FORMAT_B: begin
        packed_word = {immediate[12], immediate[10:5], rs2, rs1, funct3,
                       immediate[4:1], immediate[11], opcode};
        range_error = (signed_imm < BRANCH_MIN) || (signed_imm > BRANCH_MAX) ||
                      immediate[0];
      end
      FORMAT_U: begin
        packed_word = {immediate[31:12], rd, opcode};
        range_error = |immediate[11:0];
      end
      FORMAT_J: begin
        packed_word = {immediate[20], immediate[10:1], immediate[11],
                       immediate[19:12], rd, opcode};
        range_error = (signed_imm < JUMP_MIN) || (signed_imm > JUMP_MAX) ||
                      immediate[0];
      end
      default: packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
    endcase
    // An unencodable request still produces a word, but a zero one.
    instruction = range_error ? 32'h0 : packed_word;
    error       = range_error;
  end

endmodule

// File: rtl/instruction_encoder.sv
// Valid/ready wrapper around the packer: one registered output word, plus
// the two-beat LUI/ADDI expansion of the LI pseudo-op.
module instruction_encoder
  import instruction_encoder_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] immediate,
  input  logic        load_immediate,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instruction,
  output logic        error
);

  encoder_state_t state, next_state;
  logic [4:0]  li_rd;
  logic [11:0] li_lo;
  logic        accept, out_fire, li_fits, load_word;
  logic [31:0] li_upper;
  logic [6:0]  p_opcode;
  logic [4:0]  p_rd, p_rs1, p_rs2;
  logic [2:0]  p_funct3;
  logic [6:0]  p_funct7;
  logic [31:0] p_immediate, p_instruction;
  logic        p_error;

  assign in_ready = !reset && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign li_fits  = (immediate[31:11] == {21{immediate[11]}});
  // Rounding by 0x800 makes the sign-extended low 12 bits land back on imm.
  assign li_upper = (immediate + 32'h0000_0800) & 32'hFFFF_F000;

  // Steer the packer: the latched ADDI in EXPAND, LI rewrites, or the raw request.
  always_comb begin
    p_opcode    = opcode;
    p_rd        = rd;
    p_rs1       = rs1;
    p_rs2       = rs2;
    p_funct3    = funct3;
    p_funct7    = funct7;
    p_immediate = immediate;
    if (state == EXPAND) begin
      p_opcode    = Immediate_Arithmetic;
      p_rd        = li_rd;
      p_rs1       = li_rd;
      p_rs2       = 5'd0;
      p_funct3    = 3'd0;
      p_funct7    = 7'd0;
      p_immediate = {{20{li_lo[11]}}, li_lo};
    end else if (load_immediate) begin
      p_rs1    = 5'd0;
      p_rs2    = 5'd0;
      p_funct3 = 3'd0;
      p_funct7 = 7'd0;
      if (li_fits) begin
        p_opcode = Immediate_Arithmetic;
      end else begin
        p_opcode    = Load_Upper_Immediate;
        p_immediate = li_upper;
      end
    end
  end

  instruction_packer packer (
    .opcode      (p_opcode),
    .rd          (p_rd),
    .rs1         (p_rs1),
    .rs2         (p_rs2),
    .funct3      (p_funct3),
    .funct7      (p_funct7),
    .immediate   (p_immediate),
    .instruction (p_instruction),
    .error       (p_error)
  );

  always_comb begin
    next_state = state;
    load_word  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load_word = 1'b1;
          if (load_immediate && !li_fits) next_state = EXPAND;
        end
      end
      EXPAND: begin
        if (out_fire) begin
          load_word  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid   <= 1'b0;
      instruction <= 32'h0;
      error       <= 1'b0;
      li_rd       <= 5'd0;
      li_lo       <= 12'd0;
    end else begin
      if (load_word) begin
        out_valid   <= 1'b1;
        instruction <= p_instruction;
        error       <= p_error;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
      if (accept && load_immediate && !li_fits) begin
        li_rd <= rd;
        li_lo <= immediate[11:0];
      end
    end
  end

endmodule
